fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_unit_fifo.sv | 40 ++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;
  localparam int          ILEN         = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } fstate_e;
endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instruction} with flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + PW'(1);
      if (pop_i)  rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wp_q] <= din_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem[rp_q];
endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: fetch PC, single-outstanding imem handshake, prefetch queue.
// Optional same-cycle bypass of an ack into decode: define FETCH_BYPASS_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = ILEN + XLEN;

  fstate_e         state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] daddr_q, daddr_d;   // address of the request being dropped
  logic [CW-1:0]   count;
  logic [FW-1:0]   head;
  logic [XLEN-1:0] rpc;
  logic            ack_req, fifo_vld, byp, fifo_pop, push;
  logic [CW:0]     cnt_nxt;
  logic            unused_rpc_lsb;

  assign rpc            = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign ack_req        = (state_q == S_REQ) && imem_ack;
  assign fifo_vld       = (count != '0);

`ifdef FETCH_BYPASS_EN
  assign byp = ack_req && !redirect && !fifo_vld;
`else
  assign byp = 1'b0;
`endif

  assign fifo_pop = fifo_vld && inst_ready;
  assign push     = ack_req && !redirect && !(byp && inst_ready);
  assign cnt_nxt  = {1'b0, count} + (CW+1)'(push) - (CW+1)'(fifo_pop);

  fetch_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .din_i   ({fpc_q, imem_rdata}),
    .count_o (count),
    .head_o  (head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fpc_q   <= RESET_PC;
      daddr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    daddr_d = daddr_q;
    if (redirect) begin
      fpc_d = rpc;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (!imem_ack) begin
            state_d = S_DROP;
            daddr_d = fpc_q;
          end
        end
        // An ack here retires the abandoned request, so the new target can go out.
        S_DROP:  state_d = imem_ack ? S_REQ : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: if (count < CW'(DEPTH)) state_d = S_REQ;
        S_REQ: begin
          if (imem_ack) begin
            fpc_d   = fpc_q + XLEN'(4);
            state_d = (cnt_nxt < (CW+1)'(DEPTH)) ? S_REQ : S_IDLE;
          end
        end
        S_DROP:  if (imem_ack) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req   = (state_q != S_IDLE);
    imem_addr  = (state_q == S_DROP) ? daddr_q : fpc_q;
    inst_valid = fifo_vld || byp;
    inst       = '0;
    inst_pc    = '0;
    if (byp) begin
      inst    = imem_rdata;
      inst_pc = fpc_q;
    end else if (fifo_vld) begin
      inst    = head[ILEN-1:0];
      inst_pc = head[FW-1:ILEN];
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a queue-level reference model checked every cycle.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        imem_req, inst_valid;
  logic        imem_ack = 1'b0, inst_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
  logic [31:0] redirect_pc = '0;
  int          n_pass = 0, n_tot = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the address so each fetch is distinguishable.
  assign imem_rdata = imem_addr ^ 32'hA5C3_0F00;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: a queue of fetched {pc,word}, whether a request is in flight,
  // and whether that request's answer must be thrown away.
  logic [63:0] mq[$];
  bit          m_busy, m_disc;
  logic [31:0] m_fpc, m_daddr;

  always @(posedge clk) begin
    int osz;
    osz = mq.size();
    if (!rst) begin
      mq.delete();
      m_busy  = 1'b0;
      m_disc  = 1'b0;
      m_fpc   = 32'h3000;
      m_daddr = 32'h3000;
    end else if (redirect) begin
      if (m_busy && !imem_ack) begin
        if (!m_disc) m_daddr = m_fpc;
        m_disc = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_disc = 1'b0;
      end
      m_fpc = {redirect_pc[31:2], 2'b00};
      mq.delete();
    end else begin
      if (osz != 0 && inst_ready) void'(mq.pop_front());
      if (m_busy && imem_ack) begin
        if (m_disc) m_disc = 1'b0;
        else begin
          mq.push_back({m_fpc, imem_rdata});
          m_fpc  = m_fpc + 32'd4;
          m_busy = (mq.size() < DEPTH);
        end
      end else if (!m_busy) begin
        m_busy = (osz < DEPTH);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req",   32'(imem_req), 32'(m_busy));
      chk("m_addr",  imem_addr, (m_busy && m_disc) ? m_daddr : m_fpc);
      chk("m_valid", 32'(inst_valid), 32'(mq.size() != 0));
      chk("m_inst",  inst,    (mq.size() != 0) ? mq[0][31:0]  : 32'h0);
      chk("m_pc",    inst_pc, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  logic [15:0] rdy_pat = 16'b1010_0011_1100_0110;
  logic [15:0] ack_pat = 16'b1101_1001_0111_0011;

  initial begin
    inst_ready = 1'b1;
    imem_ack   = 1'b1;
    step(); step();
    chk_en = 1'b1;
    neg();
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);

    // Streaming from reset with ack and ready tied high.
    step(); rst = 1'b1;
    neg(); chk("rel_idle", 32'(imem_req), 32'h0);
    step(); neg();
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h3000);
    step(); neg();
    chk("stream_addr1", imem_addr, 32'h3004);
    chk("stream_pc0", inst_pc, 32'h3000);
    chk("stream_inst0", inst, 32'h3000 ^ 32'hA5C3_0F00);
    step(); neg();
    chk("stream_addr2", imem_addr, 32'h3008);
    chk("stream_pc1", inst_pc, 32'h3004);
    repeat (5) step();

    // Decode stalled: queue fills to DEPTH and fetch stops.
    rst = 1'b0; inst_ready = 1'b0;
    step(); rst = 1'b1;
    repeat (8) step();
    neg();
    chk("full_noreq", 32'(imem_req), 32'h0);
    chk("full_head", inst_pc, 32'h3000);
    inst_ready = 1'b1;
    step(); step(); neg();
    chk("resume_req", 32'(imem_req), 32'h1);
    chk("resume_addr", imem_addr, 32'h3010);
    chk("drain_pc", inst_pc, 32'h3008);
    repeat (6) step();

    // Redirect while a request waits for a late ack.
    imem_ack = 1'b0;
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h4003;
    step(); redirect = 1'b0;
    neg();
    chk("drop_valid", 32'(inst_valid), 32'h0);
    chk("drop_req", 32'(imem_req), 32'h1);
    step(); step();
    imem_ack = 1'b1;
    step(); neg();
    chk("after_drop_addr", imem_addr, 32'h4000);
    chk("after_drop_valid", 32'(inst_valid), 32'h0);
    step(); neg();
    chk("redir_pc", inst_pc, 32'h4000);
    chk("redir_inst", inst, 32'h4000 ^ 32'hA5C3_0F00);

    // Redirect coinciding with ack and pop.
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h5000;
    step(); redirect = 1'b0;
    neg();
    chk("rap_valid", 32'(inst_valid), 32'h0);
    chk("rap_addr", imem_addr, 32'h5000);
    step(); neg();
    chk("rap_pc", inst_pc, 32'h5000);

    // Wrap of the fetch PC at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(); redirect = 1'b0;
    neg(); chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(); neg();
    chk("wrap_zero", imem_addr, 32'h0000_0000);
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);

    // Mixed ready/ack patterns with redirects landing in varied states.
    for (int i = 0; i < 64; i++) begin
      inst_ready  = rdy_pat[i % 16];
      imem_ack    = ack_pat[(i * 3) % 16];
      redirect    = (i == 21) || (i == 22) || (i == 40) || (i == 55);
      redirect_pc = 32'h6000 + 32'(i * 16) + 32'(i % 4);
      step();
    end
    redirect = 1'b0;

    // Reset while a request is outstanding abandons it.
    imem_ack = 1'b0; inst_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); rst = 1'b1;
    neg();
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_addr", imem_addr, 32'h3000);
    imem_ack = 1'b1;
    repeat (6) step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
